// File: rtl/multicycle_controller.sv
// Main sequencing FSM for the multicycle RISC-V core: steps the shared datapath
// through fetch/decode/execute/memory/writeback and drives every select and enable.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [3:0] alu_ctrl,
    output logic       illegal_instr,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    state_t     cur, nxt;
    logic       legal;
    logic [3:0] funct_alu;

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LW, OP_SW: legal = (funct3 == 3'b010);
            OP_R, OP_I:   legal = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_BEQ:       legal = (funct3 == 3'b000);
            OP_JAL:       legal = 1'b1;
            default:      legal = 1'b0;
        endcase
    end

    // SUB only for R-type with funct7b5; addi shares funct3=000 but always adds.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  funct_alu = ALU_AND;
            3'b110:  funct_alu = ALU_OR;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                if (legal) begin
                    case (op)
                        OP_LW, OP_SW: nxt = MEMADR;
                        OP_R:         nxt = EXECUTER;
                        OP_I:         nxt = EXECUTEI;
                        OP_BEQ:       nxt = BEQ;
                        OP_JAL:       nxt = JAL;
                        default:      nxt = FETCH;
                    endcase
                end
            end
            MEMADR:                  nxt = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:                 nxt = MEMWB;
            EXECUTER, EXECUTEI, JAL: nxt = ALUWB;
            default:                 nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        alu_ctrl      = ALU_ADD;
        illegal_instr = 1'b0;
        case (cur)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_a     = 2'b01;
                alu_src_b     = 2'b01;
                illegal_instr = ~legal;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_ctrl  = funct_alu;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = funct_alu;
            end
            ALUWB: reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides every enable so an aborted instruction leaves no side effect.
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            mem_write     = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign state = cur;

endmodule
